frame_sequencer: RTL

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

---
 rtl/game_pkg.sv | 21 ++
 rtl/frame_phase_timer.sv | 32 +++
 rtl/frame_sequencer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the frame sequencer slice.
// Contents: sequencer state encoding, phase count and phase index constants.
package game_pkg;

    localparam int unsigned NUM_PHASES   = 3;

    // Phase indices into phase_start / phase_done
    localparam int unsigned PH_INPUT     = 0;
    localparam int unsigned PH_PHYSICS   = 1;
    localparam int unsigned PH_COLLISION = 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LATCH = 3'd1,
        S_PH0   = 3'd2,
        S_PH1   = 3'd3,
        S_PH2   = 3'd4,
        S_DONE  = 3'd5
    } seq_state_t;

endpackage

// File: rtl/frame_phase_timer.sv
// Per-phase watchdog counter.
// Ports:
//   clk, rst  - clock, async active-high reset
//   clear     - restart the count at zero (takes priority over enable)
//   enable    - count one cycle spent in the current phase
//   expired   - count has reached TIMEOUT_CYC-1
module frame_phase_timer #(
    parameter logic [31:0] TIMEOUT_CYC = 32'd1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [31:0] cnt;

    assign expired = (cnt == TIMEOUT_CYC - 32'd1);

    // Holds at the expiry value; the sequencer leaves the phase that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + 32'd1;
        end
    end

endmodule

// File: rtl/frame_sequencer.sv
// Game frame sequencer: on each game tick, freezes the buttons and runs the
// input, physics and collision phases in order, with a per-phase timeout.
// Ports:
//   clk, rst     - 100 MHz clock, async active-high reset
//   game_tick    - one-cycle frame pulse
//   btn_in       - synchronized button levels
//   clr_err      - clears timeout_err and overrun_cnt
//   phase_done   - per-phase completion pulses
//   phase_start  - per-phase one-cycle start strobes
//   btn_frame    - buttons frozen for the current frame
//   frame_busy   - high whenever a frame is in flight
//   frame_cnt    - completed frames (wraps)
//   overrun_cnt  - ticks dropped while busy (saturates)
//   timeout_err  - sticky phase-timeout flag
module frame_sequencer
    import game_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYC = 32'd1_000_000,
    parameter int unsigned OVR_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  game_tick,
    input  logic [3:0]            btn_in,
    input  logic                  clr_err,
    input  logic [NUM_PHASES-1:0] phase_done,
    output logic [NUM_PHASES-1:0] phase_start,
    output logic [3:0]            btn_frame,
    output logic                  frame_busy,
    output logic [15:0]           frame_cnt,
    output logic [OVR_W-1:0]      overrun_cnt,
    output logic                  timeout_err
);

    seq_state_t            state, state_d;
    logic [NUM_PHASES-1:0] start_d;
    logic                  phase_adv;
    logic                  timeout_ev;
    logic                  in_phase;
    logic                  expired;
    logic                  ovr_ev;

    assign in_phase = (state == S_PH0) || (state == S_PH1) || (state == S_PH2);
    assign ovr_ev   = game_tick && (state != S_IDLE);

    // Counter restarts outside phases and on every phase advance, so each
    // phase is timed from its own first cycle.
    frame_phase_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_phase || phase_adv),
        .enable  (in_phase),
        .expired (expired)
    );

    // Next state and next strobes; done is checked before timeout so a
    // same-cycle completion wins.
    always_comb begin
        state_d    = state;
        start_d    = '0;
        phase_adv  = 1'b0;
        timeout_ev = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (game_tick) state_d = S_LATCH;
            end
            S_LATCH: begin
                state_d           = S_PH0;
                start_d[PH_INPUT] = 1'b1;
            end
            S_PH0: begin
                if (phase_done[PH_INPUT]) begin
                    state_d             = S_PH1;
                    start_d[PH_PHYSICS] = 1'b1;
                    phase_adv           = 1'b1;
                end else if (expired) begin
                    state_d    = S_IDLE;
                    timeout_ev = 1'b1;
                end
            end
            S_PH1: begin
                if (phase_done[PH_PHYSICS]) begin
                    state_d               = S_PH2;
                    start_d[PH_COLLISION] = 1'b1;
                    phase_adv             = 1'b1;
                end else if (expired) begin
                    state_d    = S_IDLE;
                    timeout_ev = 1'b1;
                end
            end
            S_PH2: begin
                if (phase_done[PH_COLLISION]) begin
                    state_d   = S_DONE;
                    phase_adv = 1'b1;
                end else if (expired) begin
                    state_d    = S_IDLE;
                    timeout_ev = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            phase_start <= '0;
            btn_frame   <= '0;
            frame_busy  <= 1'b0;
            frame_cnt   <= '0;
            overrun_cnt <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            phase_start <= start_d;
            frame_busy  <= (state_d != S_IDLE);
            if (state == S_LATCH) btn_frame <= btn_in;
            if (state == S_DONE)  frame_cnt <= frame_cnt + 16'd1;
            // A tick dropped in the clearing cycle survives the clear.
            if (clr_err) begin
                overrun_cnt <= ovr_ev ? OVR_W'(1) : '0;
            end else if (ovr_ev && (overrun_cnt != '1)) begin
                overrun_cnt <= overrun_cnt + OVR_W'(1);
            end
            if (timeout_ev) begin
                timeout_err <= 1'b1;
            end else if (clr_err) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule
